freq_gate_ctrl: RTL and testbench
=================================

// Module: freq_gate_ctrl
// PURPOSE
//  Gate-time controller for the frequency counter. Sits upstream of the bcdCount digit chain.
//  Synchronises the external signal and emits one count-enable pulse per rising edge while a
//  fixed gate window is open. Clears the chain before each window and latches the chain's BCD
//  result plus an overflow flag for the display after each window. Runs free, window after window.
// PARAMETERS
//  GATE_CYCLES  100_000_000  clk cycles the gate stays open (1 s at 100 MHz); must be >= 2
//  DIGITS       4            BCD digits in the downstream chain (1..8)
//  SYNC_STAGES  2            flops in the sig_in synchroniser (>= 2)
// PORTS
//  clk       in   1         system clock, all logic on rising edge
//  reset     in   1         synchronous, active-high
//  sig_in    in   1         asynchronous signal under measurement
//  bcd_in    in   4*DIGITS  live chain value, digit 0 in [3:0]
//  carry_in  in   1         chain terminal carry, high when all digits == 9
//  cnt_en    out  1         increment pulse to the chain (1 cycle per detected edge)
//  cnt_clr   out  1         synchronous clear to the chain
//  freq_bcd  out  4*DIGITS  latched result of the last completed window
//  overflow  out  1         latched: last window exceeded 10^DIGITS-1 edges
//  valid     out  1         1-cycle pulse when freq_bcd/overflow update
// BEHAVIOUR
//  Decided interface: one clock (clk); reset is synchronous and active-high (reset).
//  Reset values: cnt_en=0, freq_bcd=0, overflow=0, valid=0, state=CLEAR, gate counter=0,
//   sync flops=0, ovf_sticky=0. cnt_clr = reset | (state==CLEAR), so it is high during reset.
//  Edge detect: sig_in -> SYNC_STAGES flops -> delay flop; rise = s_sync & ~s_dly.
//   Latency from sig_in rise to cnt_en pulse: SYNC_STAGES+1 clk.
//  FSM (registered state):
//   CLEAR  : 1 cycle, cnt_clr=1, gate counter<=0, ovf_sticky<=0 -> GATE
//   GATE   : exactly GATE_CYCLES cycles; cnt_en = rise; counter counts 0..GATE_CYCLES-1;
//            at GATE_CYCLES-1 -> SETTLE
//   SETTLE : 1 cycle, cnt_en=0; lets the last increment land in the chain -> LATCH
//   LATCH  : 1 cycle; freq_bcd<=bcd_in, overflow<=ovf_sticky, valid<=1 (visible next cycle) -> CLEAR
//  Window period: GATE_CYCLES+3 clk. Rises outside GATE are dropped, not deferred.
//  Overflow: ovf_sticky<=1 when cnt_en & carry_in (next increment wraps the chain). The flag
//   sticks for the rest of the window. freq_bcd then holds the wrapped value (count mod 10^DIGITS).
//  Boundaries:
//   - rise in the last GATE cycle: counted.
//   - rise in SETTLE, LATCH or CLEAR: ignored.
//   - sig_in stuck high/low: 0 counts; the result latches as 0.
//   - reset mid-window: immediate return to CLEAR; outputs revert to reset values;
//     no partial result and no valid pulse.
//   - freq_bcd/overflow stable between valid pulses.
//  Gate counter width: $clog2(GATE_CYCLES); no combinational path from sig_in to outputs.
// STRUCTURE
//  freq_pkg: state typedef {CLEAR, GATE, SETTLE, LATCH}; BCD_W=4; default GATE_CYCLES constant.
//  Sub-module edge_sync (SYNC_STAGES param): synchroniser + rising-edge pulse.
//  FSM, gate counter and latch stay in freq_gate_ctrl.
// TESTING  (bench drives a DIGITS-long bcdCount chain from cnt_en/cnt_clr; GATE_CYCLES=20)
//  1. sig_in period 4 clk, DIGITS=4 -> each valid: freq_bcd=16'h0005, overflow=0, valid spacing 23 clk.
//  2. sig_in toggling every clk (period 2), DIGITS=1, GATE_CYCLES=40 -> 20 edges: freq_bcd=4'h0, overflow=1.
//  3. sig_in held high, then held low -> freq_bcd=0, overflow=0, valid still pulses every 23 clk.
//  4. Single rise timed so cnt_en lands in the last GATE cycle -> freq_bcd=1.
//     Same rise shifted 1 clk later -> 0.
//  5. reset asserted 2 clk mid-GATE after a prior result of 5 -> freq_bcd=0, valid=0, cnt_clr=1;
//     the next window restarts from CLEAR and reports 5.
//  6. Glitch-free check: sig_in edge every 3 clk -> cnt_en never high 2 consecutive cycles; freq_bcd=7 or 6.

Source files
------------

// File: rtl/freq_gate_ctrl_pkg.sv
// Shared constants and state encoding for the frequency-counter gate controller.
package freq_gate_ctrl_pkg;

  localparam int BCD_W           = 4;
  localparam int DEF_GATE_CYCLES = 100_000_000;

  typedef logic [1:0] state_t;

  localparam state_t ST_CLEAR  = 2'd0;
  localparam state_t ST_GATE   = 2'd1;
  localparam state_t ST_SETTLE = 2'd2;
  localparam state_t ST_LATCH  = 2'd3;

endpackage

// File: rtl/freq_gate_ctrl_if.sv
// Link between the gate controller, the downstream BCD digit chain and the display latch.
interface freq_gate_ctrl_if #(
  parameter int DIGITS = 4
);
  import freq_gate_ctrl_pkg::*;

  logic [BCD_W*DIGITS-1:0] bcd_in;
  logic                    carry_in;
  logic                    cnt_en;
  logic                    cnt_clr;
  logic [BCD_W*DIGITS-1:0] freq_bcd;
  logic                    overflow;
  logic                    valid;

  modport master (
    input  bcd_in,
    input  carry_in,
    output cnt_en,
    output cnt_clr,
    output freq_bcd,
    output overflow,
    output valid
  );

  modport slave (
    output bcd_in,
    output carry_in,
    input  cnt_en,
    input  cnt_clr,
    input  freq_bcd,
    input  overflow,
    input  valid
  );

endinterface

// File: rtl/freq_gate_ctrl_edge_sync.sv
// Synchroniser for the asynchronous measured signal plus a registered rising-edge pulse.
module edge_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic rise
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   dly_q;

  // rise is registered so nothing downstream sees a combinational path from d
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q <= '0;
      dly_q  <= 1'b0;
      rise   <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], d};
      dly_q  <= sync_q[SYNC_STAGES-1];
      rise   <= sync_q[SYNC_STAGES-1] & ~dly_q;
    end
  end

endmodule

// File: rtl/freq_gate_ctrl.sv
// Gate-time controller: counts synchronised sig_in edges over a fixed window and
// latches the downstream BCD chain result after every window.
//  state  | meaning
//  CLEAR  | chain cleared, gate counter and overflow sticky reset
//  GATE   | window open, each synchronised rise pulses cnt_en
//  SETTLE | window closed, last increment lands in the chain
//  LATCH  | chain value and overflow captured, valid shows next cycle
module freq_gate_ctrl
  import freq_gate_ctrl_pkg::*;
#(
  parameter int GATE_CYCLES = DEF_GATE_CYCLES,
  parameter int DIGITS      = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             sig_in,
  freq_gate_ctrl_if.master bus
);

  localparam int               CNT_W     = $clog2(GATE_CYCLES);
  localparam int               RES_W     = BCD_W * DIGITS;
  localparam logic [CNT_W-1:0] GATE_LAST = CNT_W'(GATE_CYCLES - 1);

  state_t             state_q;
  logic [CNT_W-1:0]   gate_cnt_q;
  logic               ovf_sticky_q;
  logic [RES_W-1:0]   freq_q;
  logic               overflow_q;
  logic               valid_q;
  logic               rise;
  logic               cnt_en_w;

  edge_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_edge_sync (
    .clk  (clk),
    .reset(reset),
    .d    (sig_in),
    .rise (rise)
  );

  assign cnt_en_w     = (state_q == ST_GATE) & rise;
  assign bus.cnt_en   = cnt_en_w;
  assign bus.cnt_clr  = reset | (state_q == ST_CLEAR);
  assign bus.freq_bcd = freq_q;
  assign bus.overflow = overflow_q;
  assign bus.valid    = valid_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_CLEAR;
      gate_cnt_q   <= '0;
      ovf_sticky_q <= 1'b0;
      freq_q       <= '0;
      overflow_q   <= 1'b0;
      valid_q      <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      case (state_q)
        ST_CLEAR: begin
          gate_cnt_q   <= '0;
          ovf_sticky_q <= 1'b0;
          state_q      <= ST_GATE;
        end
        ST_GATE: begin
          // carry with an increment means the chain is about to wrap
          if (cnt_en_w && bus.carry_in) begin
            ovf_sticky_q <= 1'b1;
          end
          if (gate_cnt_q == GATE_LAST) begin
            state_q <= ST_SETTLE;
          end else begin
            gate_cnt_q <= gate_cnt_q + 1'b1;
          end
        end
        ST_SETTLE: begin
          state_q <= ST_LATCH;
        end
        ST_LATCH: begin
          freq_q     <= bus.bcd_in;
          overflow_q <= ovf_sticky_q;
          valid_q    <= 1'b1;
          state_q    <= ST_CLEAR;
        end
        default: begin
          state_q <= ST_CLEAR;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_freq_gate_ctrl.sv
// Bench for freq_gate_ctrl: two instances, each driving a behavioural BCD chain,
// checked every cycle against a window-level counting model plus directed results.
module tb_freq_gate_ctrl;

  localparam int GA = 20;
  localparam int DA = 4;
  localparam int GB = 40;
  localparam int DB = 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst0 = 1'b1;
  logic rst1 = 1'b1;
  logic sig0 = 1'b0;
  logic sig1 = 1'b0;

  int n_chk  = 0;
  int n_pass = 0;

  freq_gate_ctrl_if #(.DIGITS(DA)) bus_a ();
  freq_gate_ctrl_if #(.DIGITS(DB)) bus_b ();

  freq_gate_ctrl #(.GATE_CYCLES(GA), .DIGITS(DA), .SYNC_STAGES(2)) dut_a (
    .clk(clk), .reset(rst0), .sig_in(sig0), .bus(bus_a.master)
  );

  freq_gate_ctrl #(.GATE_CYCLES(GB), .DIGITS(DB), .SYNC_STAGES(2)) dut_b (
    .clk(clk), .reset(rst1), .sig_in(sig1), .bus(bus_b.master)
  );

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
  endtask

  function automatic logic [31:0] bcd_inc(input logic [31:0] v, input int d);
    logic [31:0] r;
    r = v;
    for (int i = 0; i < d; i++) begin
      if (r[4*i +: 4] == 4'd9) r[4*i +: 4] = 4'd0;
      else begin
        r[4*i +: 4] = r[4*i +: 4] + 4'd1;
        break;
      end
    end
    return r;
  endfunction

  function automatic int pow10(input int d);
    int p;
    p = 1;
    for (int i = 0; i < d; i++) p = p * 10;
    return p;
  endfunction

  function automatic logic [31:0] to_bcd(input int v, input int d);
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < d; i++) begin
      r[4*i +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

  // downstream bcdCount chains
  logic [15:0] chain_a;
  logic [3:0]  chain_b;

  always @(posedge clk) begin
    if (bus_a.cnt_clr)     chain_a <= '0;
    else if (bus_a.cnt_en) chain_a <= 16'(bcd_inc({16'd0, chain_a}, DA));
    if (bus_b.cnt_clr)     chain_b <= '0;
    else if (bus_b.cnt_en) chain_b <= 4'(bcd_inc({28'd0, chain_b}, DB));
  end

  assign bus_a.bcd_in   = chain_a;
  assign bus_a.carry_in = (chain_a == 16'h9999);
  assign bus_b.bcd_in   = chain_b;
  assign bus_b.carry_in = (chain_b == 4'h9);

  // window-level model: phase within the GATE_CYCLES+3 period, edges counted per window
  int          gcyc [2] = '{GA, GB};
  int          dig  [2] = '{DA, DB};
  int          ph   [2];
  int          mcnt [2];
  bit          rp   [2] = '{1'b1, 1'b1};
  bit          pend [2];
  bit          h1 [2], h2 [2], h3 [2], h4 [2];
  logic [31:0] ef   [2] = '{32'd0, 32'd0};
  bit          eo   [2];
  bit          ev   [2];
  bit          glitch_watch = 1'b0;
  logic        prev_en_a    = 1'b0;

  task automatic model_step(input int i, input logic r, input logic s, input logic en,
                            input logic clr, input logic [31:0] fr, input logic ov,
                            input logic va);
    bit    e_en;
    bit    e_clr;
    string nm;
    nm = (i == 0) ? "a" : "b";
    if (rp[i]) begin
      ph[i] = 0; pend[i] = 1'b0; mcnt[i] = 0;
      ef[i] = '0; eo[i] = 1'b0; ev[i] = 1'b0;
    end else begin
      ph[i] = (ph[i] + 1) % (gcyc[i] + 3);
      ev[i] = pend[i];
      if (pend[i]) begin
        ef[i]   = to_bcd(mcnt[i], dig[i]);
        eo[i]   = (mcnt[i] >= pow10(dig[i]));
        mcnt[i] = 0;
      end
    end
    e_clr = r || (ph[i] == 0);
    e_en  = (ph[i] >= 1) && (ph[i] <= gcyc[i]) && h3[i] && !h4[i];
    check({nm, "_cnt_en"},   {31'd0, en},  {31'd0, e_en});
    check({nm, "_cnt_clr"},  {31'd0, clr}, {31'd0, e_clr});
    check({nm, "_freq_bcd"}, fr,           ef[i]);
    check({nm, "_overflow"}, {31'd0, ov},  {31'd0, eo[i]});
    check({nm, "_valid"},    {31'd0, va},  {31'd0, ev[i]});
    if (e_en) mcnt[i]++;
    pend[i] = (ph[i] == gcyc[i] + 2);
    h4[i] = h3[i]; h3[i] = h2[i]; h2[i] = h1[i];
    h1[i] = r ? 1'b0 : s;
    rp[i] = r;
  endtask

  always @(negedge clk) begin
    model_step(0, rst0, sig0, bus_a.cnt_en, bus_a.cnt_clr, {16'd0, bus_a.freq_bcd},
               bus_a.overflow, bus_a.valid);
    model_step(1, rst1, sig1, bus_b.cnt_en, bus_b.cnt_clr, {28'd0, bus_b.freq_bcd},
               bus_b.overflow, bus_b.valid);
    if (glitch_watch) check("a_cnt_en_pair", {31'd0, bus_a.cnt_en & prev_en_a}, 32'd0);
    prev_en_a = bus_a.cnt_en;
  end

  // stimulus: mode 0 low, 1 high, 2 periodic with period per_x
  int mode_a = 0, per_a = 4, tc_a = 0;
  int mode_b = 0, per_b = 2, tc_b = 0;

  task automatic tick_a();
    @(posedge clk);
    #1;
    tc_a++;
    case (mode_a)
      0:       sig0 = 1'b0;
      1:       sig0 = 1'b1;
      default: sig0 = ((tc_a % per_a) < (per_a - per_a / 2));
    endcase
  endtask

  task automatic tick_b();
    @(posedge clk);
    #1;
    tc_b++;
    case (mode_b)
      0:       sig1 = 1'b0;
      1:       sig1 = 1'b1;
      default: sig1 = ((tc_b % per_b) < (per_b - per_b / 2));
    endcase
  endtask

  task automatic wait_valid_a(input string nm, output int waited);
    waited = 0;
    do begin
      tick_a();
      waited++;
    end while (!bus_a.valid && waited < 200);
    check({nm, "_valid_seen"}, {31'd0, bus_a.valid}, 32'd1);
  endtask

  task automatic wait_valid_b(input string nm, output int waited);
    waited = 0;
    do begin
      tick_b();
      waited++;
    end while (!bus_b.valid && waited < 200);
    check({nm, "_valid_seen"}, {31'd0, bus_b.valid}, 32'd1);
  endtask

  task automatic run_a();
    int w;
    repeat (4) tick_a();
    check("a_rst_cnt_clr",  {31'd0, bus_a.cnt_clr}, 32'd1);
    check("a_rst_cnt_en",   {31'd0, bus_a.cnt_en},  32'd0);
    check("a_rst_freq",     {16'd0, bus_a.freq_bcd}, 32'd0);
    check("a_rst_valid",    {31'd0, bus_a.valid},   32'd0);

    // period 4 over a 20-cycle gate
    mode_a = 2; per_a = 4; tc_a = 0;
    rst0 = 1'b0;
    wait_valid_a("t1_first", w);
    wait_valid_a("t1_second", w);
    check("t1_freq",    {16'd0, bus_a.freq_bcd}, 32'h0005);
    check("t1_ovf",     {31'd0, bus_a.overflow}, 32'd0);
    check("t1_spacing", 32'(w), 32'd23);
    wait_valid_a("t1_third", w);
    check("t1_freq_again", {16'd0, bus_a.freq_bcd}, 32'h0005);

    // stuck high, then stuck low
    mode_a = 1;
    wait_valid_a("t3_rise", w);
    wait_valid_a("t3_high", w);
    check("t3_high_freq",    {16'd0, bus_a.freq_bcd}, 32'd0);
    check("t3_high_ovf",     {31'd0, bus_a.overflow}, 32'd0);
    check("t3_high_spacing", 32'(w), 32'd23);
    mode_a = 0;
    wait_valid_a("t3_low", w);
    check("t3_low_freq",    {16'd0, bus_a.freq_bcd}, 32'd0);
    check("t3_low_spacing", 32'(w), 32'd23);

    // single rise landing in the last gate cycle, then one cycle later
    repeat (16) tick_a();
    mode_a = 1;
    tick_a();
    wait_valid_a("t4_last", w);
    check("t4_last_gate_freq", {16'd0, bus_a.freq_bcd}, 32'd1);
    mode_a = 0;
    wait_valid_a("t4_quiet", w);
    check("t4_quiet_freq", {16'd0, bus_a.freq_bcd}, 32'd0);
    repeat (17) tick_a();
    mode_a = 1;
    tick_a();
    wait_valid_a("t4_settle", w);
    check("t4_settle_freq", {16'd0, bus_a.freq_bcd}, 32'd0);

    // reset for two cycles in the middle of a gate window
    mode_a = 2; per_a = 4;
    wait_valid_a("t5_warm", w);
    wait_valid_a("t5_prior", w);
    check("t5_prior_freq", {16'd0, bus_a.freq_bcd}, 32'h0005);
    repeat (8) tick_a();
    rst0 = 1'b1;
    mode_a = 0;
    tick_a();
    check("t5_rst_freq",    {16'd0, bus_a.freq_bcd}, 32'd0);
    check("t5_rst_valid",   {31'd0, bus_a.valid},    32'd0);
    check("t5_rst_cnt_clr", {31'd0, bus_a.cnt_clr},  32'd1);
    tick_a();
    rst0 = 1'b0;
    mode_a = 2; tc_a = 3;
    wait_valid_a("t5_restart", w);
    check("t5_restart_spacing", 32'(w), 32'd23);
    check("t5_restart_freq", {16'd0, bus_a.freq_bcd}, 32'h0005);

    // rise every 3 clk
    per_a = 3;
    glitch_watch = 1'b1;
    wait_valid_a("t6_warm", w);
    wait_valid_a("t6_steady", w);
    check("t6_freq_6_or_7",
          {31'd0, (bus_a.freq_bcd == 16'h0006) || (bus_a.freq_bcd == 16'h0007)}, 32'd1);
    glitch_watch = 1'b0;
    mode_a = 0;
    repeat (3) tick_a();
  endtask

  task automatic run_b();
    int w;
    repeat (4) tick_b();
    check("b_rst_freq", {28'd0, bus_b.freq_bcd}, 32'd0);
    mode_b = 2; per_b = 2; tc_b = 0;
    rst1 = 1'b0;
    wait_valid_b("t2_first", w);
    wait_valid_b("t2_second", w);
    check("t2_freq",    {28'd0, bus_b.freq_bcd}, 32'd0);
    check("t2_ovf",     {31'd0, bus_b.overflow}, 32'd1);
    check("t2_spacing", 32'(w), 32'd43);
    wait_valid_b("t2_third", w);
    check("t2_freq_again", {28'd0, bus_b.freq_bcd}, 32'd0);
    check("t2_ovf_again",  {31'd0, bus_b.overflow}, 32'd1);
    mode_b = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    fork
      run_a();
      run_b();
    join
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
